// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM block.
// Channel index width, channel limit and counter direction enum.
package pwm_pkg;

    localparam int PWM_CH_IDX_W     = 4;
    localparam int PWM_MAX_CHANNELS = 16;

    typedef enum logic {
        PWM_UP,
        PWM_DOWN
    } pwm_dir_e;

endpackage

// File: rtl/pwm_multi_if.sv
// Control/output bundle between register logic and the PWM block.
// master = controller side, slave = pwm_multi side.
interface pwm_multi_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    import pwm_pkg::*;

    logic                    enable;
    logic [WIDTH-1:0]        period;
    logic                    duty_wr;
    logic [PWM_CH_IDX_W-1:0] duty_ch;
    logic [WIDTH-1:0]        duty_data;
    logic [CHANNELS-1:0]     pwm_out;
    logic                    period_strobe;

    modport master (
        output enable,
        output period,
        output duty_wr,
        output duty_ch,
        output duty_data,
        input  pwm_out,
        input  period_strobe
    );

    modport slave (
        input  enable,
        input  period,
        input  duty_wr,
        input  duty_ch,
        input  duty_data,
        output pwm_out,
        output period_strobe
    );

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: duty shadow/active registers, compare, polarity,
// registered output.
module pwm_channel #(
    parameter int WIDTH = 8,
    parameter bit POL   = 1'b0
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm
);

    logic [WIDTH-1:0] duty_sh;
    logic [WIDTH-1:0] duty_q;

    // A write on a load cycle lands in the shadow while the active
    // register takes the previous shadow value.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            duty_sh <= '0;
            duty_q  <= '0;
            pwm     <= POL;
        end else begin
            if (wr) begin
                duty_sh <= wr_data;
            end
            if (load) begin
                duty_q <= duty_sh;
            end
            pwm <= (enable && (cnt < duty_q)) ^ POL;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, double-buffered period/duty.
// Define PWM_CENTER_ALIGNED_EN for up/down (center-aligned) counting.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int                  WIDTH    = 8,
    parameter int                  CHANNELS = 4,
    parameter logic [CHANNELS-1:0] POLARITY = '0
) (
    input logic        clock_in,
    input logic        reset,
    pwm_multi_if.slave bus
);

    if (CHANNELS < 1 || CHANNELS > PWM_MAX_CHANNELS) begin : g_bad_cfg
        $error("pwm_multi: CHANNELS out of range");
    end

    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    cnt_nxt;
    logic [WIDTH-1:0]    period_q;
    logic                boundary;
    logic                load;
    logic [CHANNELS-1:0] wr_sel;
    logic [CHANNELS-1:0] pwm_vec;

`ifdef PWM_CENTER_ALIGNED_EN
    pwm_dir_e         dir;
    pwm_dir_e         dir_nxt;
    logic [WIDTH-1:0] peak;

    assign peak     = (period_q == '0) ? WIDTH'(1) : period_q;
    assign boundary = bus.enable && (cnt == '0);

    always_comb begin
        dir_nxt = dir;
        cnt_nxt = '0;
        if (!bus.enable) begin
            dir_nxt = PWM_UP;
        end else if (dir == PWM_UP) begin
            if (cnt >= peak) begin
                cnt_nxt = cnt - 1'b1;
                dir_nxt = PWM_DOWN;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else if (cnt == '0) begin
            cnt_nxt = WIDTH'(1);
            dir_nxt = PWM_UP;
        end else begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            dir <= PWM_UP;
        end else begin
            dir <= dir_nxt;
        end
    end
`else
    assign boundary = bus.enable && (cnt == period_q);

    always_comb begin
        cnt_nxt = '0;
        if (bus.enable && !boundary) begin
            cnt_nxt = cnt + 1'b1;
        end
    end
`endif

    // While idle the shadows flow straight through to the active copies.
    assign load              = !bus.enable || boundary;
    assign bus.period_strobe = boundary && !reset;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            cnt      <= '0;
            period_q <= '1;
        end else begin
            cnt <= cnt_nxt;
            if (load) begin
                period_q <= bus.period;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign wr_sel[c] = bus.duty_wr &&
                           (bus.duty_ch == PWM_CH_IDX_W'(c));

        pwm_channel #(
            .WIDTH (WIDTH),
            .POL   (POLARITY[c])
        ) u_ch (
            .clock_in (clock_in),
            .reset    (reset),
            .enable   (bus.enable),
            .load     (load),
            .wr       (wr_sel[c]),
            .wr_data  (bus.duty_data),
            .cnt      (cnt),
            .pwm      (pwm_vec[c])
        );
    end

    assign bus.pwm_out = pwm_vec;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi (WIDTH=8, CHANNELS=4, POLARITY=4'b0100).
// Expected per-cycle outputs are queued from stimulus, then popped and compared.
module tb_pwm_multi;

    typedef struct {
        logic [3:0] pwm;
        logic       stb;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    pwm_multi_if #(.WIDTH(8), .CHANNELS(4)) bif ();

    pwm_multi #(
        .WIDTH    (8),
        .CHANNELS (4),
        .POLARITY (4'b0100)
    ) dut (
        .clock_in (clk),
        .reset    (reset),
        .bus      (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.enable  = 1'b0;
        bif.duty_wr = 1'b0;
        tick();
    endtask

    task automatic wr_duty(input logic [3:0] ch, input logic [7:0] d);
        bif.duty_wr   = 1'b1;
        bif.duty_ch   = ch;
        bif.duty_data = d;
        tick();
        bif.duty_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bif.enable    = 1'b1;
        bif.period    = 8'd0;
        bif.duty_wr   = 1'b0;
        bif.duty_ch   = 4'd0;
        bif.duty_data = 8'd0;
        tick();
        tick();
        n_checks++;
        if (bif.pwm_out !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_pwm got=%b exp=0100", bif.pwm_out);
        end
        n_checks++;
        if (bif.period_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stb got=%b exp=0", bif.period_strobe);
        end
        reset      = 1'b0;
        bif.enable = 1'b0;
        tick();
    endtask

    // period 9, ch0 duty 3; a mid-period change of the period input is ignored
    task automatic test_basic();
        exp_t e;
        idle();
        bif.period = 8'd9;
        wr_duty(4'd0, 8'd3);
        tick();
        for (int j = 1; j <= 30; j++) begin
            e.pwm = {3'b010, ((j - 1) % 10) < 3};
            e.stb = (j % 10) == 9;
            sb.push_back(e);
        end
        bif.enable = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            tick();
            e = sb.pop_front();
            n_checks++;
            if (bif.pwm_out !== e.pwm) begin
                n_fail++;
                $display("FAIL basic_pwm j=%0d got=%b exp=%b",
                         j, bif.pwm_out, e.pwm);
            end
            n_checks++;
            if (bif.period_strobe !== e.stb) begin
                n_fail++;
                $display("FAIL basic_stb j=%0d got=%b exp=%b",
                         j, bif.period_strobe, e.stb);
            end
            if (j == 3) bif.period = 8'd5;
            if (j == 7) bif.period = 8'd9;
        end
    endtask

    task automatic test_extremes();
        exp_t e;
        idle();
        wr_duty(4'd1, 8'd0);
        wr_duty(4'd3, 8'd10);
        wr_duty(4'd2, 8'd0);
        tick();
        for (int j = 1; j <= 20; j++) begin
            e.pwm = {3'b110, ((j - 1) % 10) < 3};
            e.stb = (j % 10) == 9;
            sb.push_back(e);
        end
        bif.enable = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            tick();
            e = sb.pop_front();
            n_checks++;
            if (bif.pwm_out !== e.pwm) begin
                n_fail++;
                $display("FAIL extreme_pwm j=%0d got=%b exp=%b",
                         j, bif.pwm_out, e.pwm);
            end
        end
    endtask

    task automatic test_mid_write();
        exp_t e;
        int   ph;
        int   d1;
        idle();
        wr_duty(4'd1, 8'd5);
        tick();
        for (int j = 1; j <= 30; j++) begin
            ph    = (j - 1) % 10;
            d1    = ((j - 1) / 10 == 0) ? 5 : 2;
            e.pwm = {2'b11, ph < d1, ph < 3};
            e.stb = (j % 10) == 9;
            sb.push_back(e);
        end
        bif.enable = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            tick();
            e = sb.pop_front();
            n_checks++;
            if (bif.pwm_out !== e.pwm) begin
                n_fail++;
                $display("FAIL midwr_pwm j=%0d got=%b exp=%b",
                         j, bif.pwm_out, e.pwm);
            end
            bif.duty_wr = 1'b0;
            if (j == 1) begin
                bif.duty_wr   = 1'b1;
                bif.duty_ch   = 4'd1;
                bif.duty_data = 8'd2;
            end
        end
    endtask

    task automatic test_boundary_write();
        exp_t e;
        int   ph;
        int   d0;
        idle();
        tick();
        for (int j = 1; j <= 30; j++) begin
            ph    = (j - 1) % 10;
            d0    = ((j - 1) / 10 < 2) ? 3 : 7;
            e.pwm = {2'b11, ph < 2, ph < d0};
            e.stb = (j % 10) == 9;
            sb.push_back(e);
        end
        bif.enable = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            tick();
            e = sb.pop_front();
            n_checks++;
            if (bif.pwm_out !== e.pwm) begin
                n_fail++;
                $display("FAIL bndwr_pwm j=%0d got=%b exp=%b",
                         j, bif.pwm_out, e.pwm);
            end
            n_checks++;
            if (bif.period_strobe !== e.stb) begin
                n_fail++;
                $display("FAIL bndwr_stb j=%0d got=%b exp=%b",
                         j, bif.period_strobe, e.stb);
            end
            bif.duty_wr = 1'b0;
            if (j == 9) begin
                bif.duty_wr   = 1'b1;
                bif.duty_ch   = 4'd0;
                bif.duty_data = 8'd7;
            end
        end
    endtask

    task automatic test_period_zero();
        exp_t e;
        idle();
        bif.period = 8'd0;
        tick();
        for (int j = 1; j <= 5; j++) begin
            e.pwm = 4'b1111;
            e.stb = 1'b1;
            sb.push_back(e);
        end
        bif.enable = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            tick();
            e = sb.pop_front();
            n_checks++;
            if (bif.pwm_out !== e.pwm) begin
                n_fail++;
                $display("FAIL p0_pwm j=%0d got=%b exp=%b",
                         j, bif.pwm_out, e.pwm);
            end
            n_checks++;
            if (bif.period_strobe !== e.stb) begin
                n_fail++;
                $display("FAIL p0_stb j=%0d got=%b exp=%b",
                         j, bif.period_strobe, e.stb);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        idle();
        bif.period = 8'd9;
        tick();
        bif.enable = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (bif.pwm_out !== 4'b0100) begin
            n_fail++;
            $display("FAIL rstmid_pwm got=%b exp=0100", bif.pwm_out);
        end
        n_checks++;
        if (bif.period_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_stb got=%b exp=0", bif.period_strobe);
        end
        reset      = 1'b0;
        bif.enable = 1'b0;
        wr_duty(4'd7, 8'd5);
        tick();
        for (int j = 1; j <= 12; j++) begin
            e.pwm = 4'b0100;
            e.stb = (j % 10) == 9;
            sb.push_back(e);
        end
        bif.enable = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            e = sb.pop_front();
            n_checks++;
            if (bif.pwm_out !== e.pwm) begin
                n_fail++;
                $display("FAIL badch_pwm j=%0d got=%b exp=%b",
                         j, bif.pwm_out, e.pwm);
            end
            n_checks++;
            if (bif.period_strobe !== e.stb) begin
                n_fail++;
                $display("FAIL badch_stb j=%0d got=%b exp=%b",
                         j, bif.period_strobe, e.stb);
            end
        end
    endtask

`ifdef PWM_CENTER_ALIGNED_EN
    task automatic test_center();
        exp_t e;
        int   cseq [8];
        cseq = '{0, 1, 2, 3, 4, 3, 2, 1};
        idle();
        wr_duty(4'd0, 8'd2);
        bif.period = 8'd4;
        tick();
        for (int j = 1; j <= 24; j++) begin
            e.pwm = {3'b010, cseq[(j - 1) % 8] < 2};
            e.stb = cseq[j % 8] == 0;
            sb.push_back(e);
        end
        bif.enable = 1'b1;
        for (int j = 1; j <= 24; j++) begin
            tick();
            e = sb.pop_front();
            n_checks++;
            if (bif.pwm_out !== e.pwm) begin
                n_fail++;
                $display("FAIL center_pwm j=%0d got=%b exp=%b",
                         j, bif.pwm_out, e.pwm);
            end
            n_checks++;
            if (bif.period_strobe !== e.stb) begin
                n_fail++;
                $display("FAIL center_stb j=%0d got=%b exp=%b",
                         j, bif.period_strobe, e.stb);
            end
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
`ifdef PWM_CENTER_ALIGNED_EN
        test_center();
`else
        test_basic();
        test_extremes();
        test_mid_write();
        test_boundary_write();
        test_period_zero();
        test_reset_mid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
